dds_core: RTL and testbench

Direct digital synthesis engine that consumes the tuning word, enable and commit strobe from the UART command decoder. It sits directly downstream of the decoder and upstream of the 8-bit parallel DAC pins. It runs a 32-bit phase accumulator, maps phase to amplitude through a quarter-wave sine ROM, and presents one DAC sample per clock with a cycle-wrap sync pulse.

---
 rtl/dds_core.sv | 179 +++++++++++++++++
 tb/tb_dds_core.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dds_core.sv
// ---------------------------------------------------------------------------
// dds_core -- direct digital synthesis engine.
//
// This block runs a phase accumulator that advances by the tuning word on
// every clock. The phase is folded onto a quarter-wave sine ROM, and the
// ROM output is unfolded into an unsigned DAC sample centred on mid-scale.
// The tuning word is loaded from the command decoder only when the commit
// strobe is high, so a retune never resets the phase.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en         run enable (level)
//   m          staged tuning word, loaded when set=1
//   set        commit strobe for m
//   dac        unsigned sample; mid-scale when no valid sample is present
//   dac_valid  dac carries a synthesized sample
//   sync       one-cycle marker on the sample that starts a waveform period
//   active     registered copy of en (accumulator running)
//
// Pipeline: acc -> stage 1 (quadrant fold) -> stage 2 (ROM read)
//           -> stage 3 (unfold), so dac lags the accumulator by 3 cycles.
// ---------------------------------------------------------------------------
module dds_core #(
    parameter int ACC_W  = 32,
    parameter int LUT_AW = 8,
    parameter int OUT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [ACC_W-1:0] m,
    input  logic             set,
    output logic [OUT_W-1:0] dac,
    output logic             dac_valid,
    output logic             sync,
    output logic             active
);

    localparam int               LUT_N     = 2 ** LUT_AW;
    localparam logic [OUT_W-1:0] MID_SCALE = {1'b1, {(OUT_W-1){1'b0}}};

    // Quarter-wave table entry, evaluated at elaboration time only.
    // The sine is a Taylor series taken to x^17. Over 0..pi/2 the error is
    // far below one LSB, so every entry rounds the same way as an exact sine.
    function automatic logic [OUT_W-2:0] lut_entry(input int idx);
        real x;
        real x2;
        real term;
        real sin_x;
        real amp;
        int  v;
        x     = 1.5707963267948966 * (real'(idx) + 0.5) / real'(LUT_N);
        x2    = x * x;
        term  = x;
        sin_x = x;
        for (int k = 1; k <= 8; k++) begin
            term  = -term * x2 / real'((2 * k) * (2 * k + 1));
            sin_x = sin_x + term;
        end
        amp = real'(2 ** (OUT_W - 1) - 1);
        v   = $rtoi(amp * sin_x + 0.5);
        return (OUT_W-1)'(v);
    endfunction

    // Constant quarter-wave ROM contents.
    logic [OUT_W-2:0] rom_s [LUT_N];

    for (genvar gi = 0; gi < LUT_N; gi++) begin : g_rom
        localparam logic [OUT_W-2:0] ENTRY = lut_entry(gi);
        assign rom_s[gi] = ENTRY;
    end

    logic [ACC_W-1:0]  ftw_r;
    logic [ACC_W-1:0]  acc_r;
    logic              start0_r;
    logic [ACC_W:0]    sum_s;
    logic [LUT_AW-1:0] phase_idx_s;

    logic              neg1_r;
    logic [LUT_AW-1:0] addr1_r;
    logic              valid1_r;
    logic              start1_r;

    logic              neg2_r;
    logic [OUT_W-2:0]  lut2_r;
    logic              valid2_r;
    logic              start2_r;

    // The carry-out of the phase increment marks a waveform wrap.
    assign sum_s       = {1'b0, acc_r} + {1'b0, ftw_r};
    assign phase_idx_s = acc_r[ACC_W-3 -: LUT_AW];

    // Tuning word: loaded on any commit, independent of the enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ftw_r <= '0;
        end else if (set) begin
            ftw_r <= m;
        end else begin
            ftw_r <= ftw_r;
        end
    end

    // Phase accumulator and its sample tag (valid = active, start flag).
    // On the first enabled edge the phase is held at zero, so the first
    // sample is always phase 0 and is always marked as a period start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r    <= '0;
            active   <= 1'b0;
            start0_r <= 1'b0;
        end else if (!en) begin
            acc_r    <= '0;
            active   <= 1'b0;
            start0_r <= 1'b0;
        end else if (!active) begin
            acc_r    <= '0;
            active   <= 1'b1;
            start0_r <= 1'b1;
        end else begin
            acc_r    <= sum_s[ACC_W-1:0];
            active   <= 1'b1;
            start0_r <= sum_s[ACC_W];
        end
    end

    // Stage 1: fold the phase into the first quadrant.
    // Quadrants 1 and 3 run the table backwards. Quadrants 2 and 3 are the
    // negative half-wave.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg1_r   <= 1'b0;
            addr1_r  <= '0;
            valid1_r <= 1'b0;
            start1_r <= 1'b0;
        end else begin
            neg1_r   <= acc_r[ACC_W-1];
            addr1_r  <= acc_r[ACC_W-2] ? ~phase_idx_s : phase_idx_s;
            valid1_r <= active;
            start1_r <= start0_r;
        end
    end

    // Stage 2: registered ROM read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg2_r   <= 1'b0;
            lut2_r   <= '0;
            valid2_r <= 1'b0;
            start2_r <= 1'b0;
        end else begin
            neg2_r   <= neg1_r;
            lut2_r   <= rom_s[addr1_r];
            valid2_r <= valid1_r;
            start2_r <= start1_r;
        end
    end

    // Stage 3: unfold around mid-scale.
    // The positive half gives MID + lut, which is {1, lut}. The negative half
    // gives MID - 1 - lut, which is {0, ~lut}. Neither form can overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dac       <= MID_SCALE;
            dac_valid <= 1'b0;
            sync      <= 1'b0;
        end else if (valid2_r) begin
            dac       <= neg2_r ? {1'b0, ~lut2_r} : {1'b1, lut2_r};
            dac_valid <= 1'b1;
            sync      <= start2_r;
        end else begin
            dac       <= MID_SCALE;
            dac_valid <= 1'b0;
            sync      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dds_core.sv
// Self-checking bench for dds_core.
// The reference model tracks phase as plain integers and computes each
// sample directly from a real-valued sine. A queue supplies the 3-cycle
// output latency.
module tb_dds_core;

    logic        clk;
    logic        rst;
    logic        en;
    logic        set;
    logic [31:0] m;
    logic [7:0]  dac;
    logic        dac_valid;
    logic        sync;
    logic        active;

    dds_core #(.ACC_W(32), .LUT_AW(8), .OUT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .m         (m),
        .set       (set),
        .dac       (dac),
        .dac_valid (dac_valid),
        .sync      (sync),
        .active    (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        v;
        bit        st;
        bit [31:0] ph;
    } tag_t;

    tag_t        pipe[$];
    bit   [31:0] mdl_ftw;
    bit   [31:0] mdl_acc;
    bit          mdl_act;
    logic [7:0]  exp_dac;
    logic        exp_valid;
    logic        exp_sync;
    logic        exp_act;
    int          n_vec = 0;
    int          n_bad = 0;

    // Ideal sample for a given phase, computed from the quarter-wave rule.
    function automatic logic [7:0] wave(input bit [31:0] ph);
        int  q;
        int  idx;
        int  amp;
        real x;
        q   = int'(ph[31:30]);
        idx = int'(ph[29:22]);
        if (q == 1 || q == 3) idx = 255 - idx;
        x   = 3.14159265358979 / 2.0 * (real'(idx) + 0.5) / 256.0;
        amp = $rtoi(127.0 * $sin(x) + 0.5);
        if (q < 2) return 8'(128 + amp);
        else       return 8'(127 - amp);
    endfunction

    task automatic model_reset();
        tag_t t;
        t.v = 1'b0; t.st = 1'b0; t.ph = 32'd0;
        mdl_ftw = 32'd0;
        mdl_acc = 32'd0;
        mdl_act = 1'b0;
        pipe.delete();
        for (int i = 0; i < 3; i++) pipe.push_back(t);
    endtask

    task automatic model_edge();
        tag_t      t;
        tag_t      e;
        bit [32:0] sum;
        e = pipe.pop_front();
        t.v = 1'b0; t.st = 1'b0;
        if (!en) begin
            mdl_acc = 32'd0;
            mdl_act = 1'b0;
        end else if (!mdl_act) begin
            mdl_act = 1'b1;
            mdl_acc = 32'd0;
            t.v = 1'b1; t.st = 1'b1;
        end else begin
            sum     = {1'b0, mdl_acc} + {1'b0, mdl_ftw};
            mdl_acc = sum[31:0];
            t.v     = 1'b1;
            t.st    = sum[32];
        end
        if (set) mdl_ftw = m;
        t.ph = mdl_acc;
        pipe.push_back(t);
        exp_valid = e.v;
        exp_sync  = e.v & e.st;
        exp_dac   = e.v ? wave(e.ph) : 8'h80;
        exp_act   = mdl_act;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive the inputs, advance the model, then compare outputs.
    task automatic cyc(input logic e, input logic s, input logic [31:0] mm);
        en = e; set = s; m = mm;
        @(posedge clk);
        model_edge();
        #1;
        check("dac",       32'(dac),       32'(exp_dac));
        check("dac_valid", 32'(dac_valid), 32'(exp_valid));
        check("sync",      32'(sync),      32'(exp_sync));
        check("active",    32'(active),    32'(exp_act));
    endtask

    logic [7:0] pat [4];
    logic [7:0] rec [256];
    int         j;
    int         syncs;
    int         mx;
    int         mn;

    initial begin
        pat[0] = 8'd128; pat[1] = 8'd255; pat[2] = 8'd127; pat[3] = 8'd0;
        rst = 1'b1; en = 1'b0; set = 1'b0; m = 32'd0;
        #12;
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_dac",    32'(dac),       32'h80);
        check("rst_valid",  32'(dac_valid), 32'd0);
        check("rst_sync",   32'(sync),      32'd0);
        check("rst_active", 32'(active),    32'd0);

        // Idle after release: the outputs hold their reset values until en.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 32'hDEADBEEF);
            check("idle_valid", 32'(dac_valid), 32'd0);
        end

        // Quarter-period tone: the output repeats 128, 255, 127, 0.
        // Changing m without set leaves the tone unchanged.
        cyc(1'b0, 1'b1, 32'h40000000);
        for (int i = 0; i < 20; i++) begin
            if (i == 16)      cyc(1'b1, 1'b1, 32'h01000000);
            else if (i >= 12) cyc(1'b1, 1'b0, $urandom);
            else              cyc(1'b1, 1'b0, 32'd0);
            if (i >= 3) begin
                j = i - 3;
                check("quad_dac",  32'(dac),  32'(pat[j % 4]));
                check("quad_sync", 32'(sync), (j % 4 == 0) ? 32'd1 : 32'd0);
            end else begin
                check("lat_valid", 32'(dac_valid), 32'd0);
            end
        end

        // A 256-sample period: half-wave symmetry, full range, one sync.
        syncs = 0; mx = 0; mn = 255;
        for (int i = 0; i < 256; i++) begin
            cyc(1'b1, 1'b0, 32'd0);
            rec[i] = dac;
            if (sync) syncs++;
            if (int'(dac) > mx) mx = int'(dac);
            if (int'(dac) < mn) mn = int'(dac);
        end
        for (int k = 0; k < 128; k++)
            check("half_sym", 32'(rec[k]) + 32'(rec[k + 128]), 32'd255);
        check("p256_max",   32'(mx),    32'd255);
        check("p256_min",   32'(mn),    32'd0);
        check("p256_syncs", 32'(syncs), 32'd1);

        // Drop en: three more valid samples, then mid-scale.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 32'd0);
            check("drain_valid", 32'(dac_valid), (i < 3) ? 32'd1 : 32'd0);
            if (i >= 3) check("drain_dac", 32'(dac), 32'h80);
        end

        // Re-enable: the first sample is 128 and carries sync.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'd0);
        check("reen_dac",  32'(dac),  32'd128);
        check("reen_sync", 32'(sync), 32'd1);

        // ftw=0 loaded on the same edge that enables: constant mid-scale.
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'd0);
        syncs = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1'b1, (i == 0) ? 1'b1 : 1'b0, 32'd0);
            if (sync) syncs++;
            if (i >= 3) begin
                check("dc_dac",   32'(dac),       32'd128);
                check("dc_valid", 32'(dac_valid), 32'd1);
            end
        end
        check("dc_syncs", 32'(syncs), 32'd1);

        // Asynchronous reset mid-run takes effect without a clock edge.
        for (int i = 0; i < 10; i++) cyc(1'b1, (i == 0) ? 1'b1 : 1'b0, 32'h12345678);
        #2 rst = 1'b1;
        #1;
        check("arst_dac",    32'(dac),       32'h80);
        check("arst_valid",  32'(dac_valid), 32'd0);
        check("arst_sync",   32'(sync),      32'd0);
        check("arst_active", 32'(active),    32'd0);
        model_reset();
        #2 rst = 1'b0;
        // ftw is cleared, so enabling without a new set yields mid-scale.
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 32'h0F0F0F0F);
        check("arst_ftw0", 32'(dac), 32'd128);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rm;
            rm = $urandom >> ($urandom % 24);
            cyc(($urandom % 16) != 0, ($urandom % 8) == 0, rm);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
